// File: rtl/wb_rst_seq.sv
// Wishbone SYSCON reset sequencer: merges reset requests, drains the bus (bounded),
// then drives a minimum-width reset pulse with async released before sync.
module wb_rst_seq #(
  parameter int unsigned REQ_CNT      = 4,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned RELEASE_GAP  = 4
) (
  input  logic               clk_i,
  input  logic               sync_rst_i,
  input  logic [REQ_CNT-1:0] req_i,
  input  logic               bus_cyc_i,
  output logic               async_rst_o,
  output logic               sync_rst_o,
  output logic [REQ_CNT-1:0] cause_o,
  output logic               forced_o,
  output logic               busy_o
);

  localparam int unsigned MAX_A = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned MAX_V = (MAX_A > RELEASE_GAP) ? MAX_A : RELEASE_GAP;
  localparam int unsigned CW    = (MAX_V > 0) ? $clog2(MAX_V + 1) : 1;
  localparam bit          NO_DRAIN = (DRAIN_CYCLES == 0);
  localparam bit          HAS_GAP  = (RELEASE_GAP > 0);
  localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(NO_DRAIN ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(HAS_GAP ? RELEASE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [REQ_CNT-1:0] cause_nxt;
  logic               forced_nxt;
  logic               async_nxt, sync_nxt, busy_nxt;
  logic               any_req;

  assign any_req = |req_i;

  // State, counter and registered outputs; sync_rst_i overrides everything.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state       <= ST_ASSERT;
      cnt         <= RST_LOAD;
      async_rst_o <= 1'b1;
      sync_rst_o  <= 1'b1;
      busy_o      <= 1'b1;
      cause_o     <= '0;
      forced_o    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      async_rst_o <= async_nxt;
      sync_rst_o  <= sync_nxt;
      busy_o      <= busy_nxt;
      cause_o     <= cause_nxt;
      forced_o    <= forced_nxt;
    end
  end

  // Next-state logic; reset lines follow the state one cycle later.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cause_nxt  = cause_o;
    forced_nxt = forced_o;
    async_nxt  = (state == ST_ASSERT);
    sync_nxt   = (state == ST_ASSERT) || (state == ST_RELEASE);
    busy_nxt   = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          cause_nxt  = req_i;
          forced_nxt = 1'b0;
          if (!bus_cyc_i || NO_DRAIN) begin
            state_nxt  = ST_ASSERT;
            cnt_nxt    = RST_LOAD;
            forced_nxt = bus_cyc_i;
          end else begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = DRAIN_LOAD;
          end
        end
      end

      ST_DRAIN: begin
        cause_nxt = cause_o | req_i;
        if (!bus_cyc_i) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = RST_LOAD;
        end else if (cnt == '0) begin
          state_nxt  = ST_ASSERT;
          cnt_nxt    = RST_LOAD;
          forced_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      ST_ASSERT: begin
        cause_nxt = cause_o | req_i;
        if (any_req) begin
          cnt_nxt = RST_LOAD;
        end else if (cnt == '0) begin
          if (HAS_GAP) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      ST_RELEASE: begin
        if (any_req) begin
          cause_nxt = cause_o | req_i;
          state_nxt = ST_ASSERT;
          cnt_nxt   = RST_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rst_seq.sv
// Bench for wb_rst_seq: directed scenarios plus random traffic, checked every cycle
// against a deadline-based reference model.
module tb_wb_rst_seq;

  localparam int unsigned REQ_CNT      = 4;
  localparam int unsigned RST_CYCLES   = 16;
  localparam int unsigned DRAIN_CYCLES = 64;
  localparam int unsigned RELEASE_GAP  = 4;

  localparam int M_IDLE = 0, M_DRAIN = 1, M_HOLD = 2, M_GAP = 3;

  logic               clk;
  logic               rst;
  logic [REQ_CNT-1:0] req;
  logic               bus_cyc;
  logic               async_rst, sync_rst, forced, busy;
  logic [REQ_CNT-1:0] cause;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase plus the edge number at which the phase expires.
  int                 mode = M_IDLE;
  int                 prev_mode = M_IDLE;
  int                 deadline = 0;
  int                 edge_n = 0;
  logic [REQ_CNT-1:0] m_cause = '0;
  logic               m_forced = 1'b0;
  logic               m_rst_now = 1'b0;

  wb_rst_seq #(
    .REQ_CNT(REQ_CNT), .RST_CYCLES(RST_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .RELEASE_GAP(RELEASE_GAP)
  ) dut (
    .clk_i(clk), .sync_rst_i(rst), .req_i(req), .bus_cyc_i(bus_cyc),
    .async_rst_o(async_rst), .sync_rst_o(sync_rst), .cause_o(cause),
    .forced_o(forced), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic enter_hold();
    mode     = M_HOLD;
    deadline = edge_n + int'(RST_CYCLES);
  endtask

  // Advance the model by one clock edge with the inputs sampled there.
  task automatic model(input logic [REQ_CNT-1:0] r, input logic b, input logic s);
    edge_n++;
    prev_mode = mode;
    m_rst_now = s;
    if (s) begin
      enter_hold();
      m_cause  = '0;
      m_forced = 1'b0;
    end else begin
      case (mode)
        M_IDLE: if (r != 0) begin
          m_cause  = r;
          m_forced = 1'b0;
          if (!b || DRAIN_CYCLES == 0) begin
            enter_hold();
            m_forced = b;
          end else begin
            mode     = M_DRAIN;
            deadline = edge_n + int'(DRAIN_CYCLES);
          end
        end
        M_DRAIN: begin
          m_cause = m_cause | r;
          if (!b) enter_hold();
          else if (edge_n >= deadline) begin
            enter_hold();
            m_forced = 1'b1;
          end
        end
        M_HOLD: begin
          m_cause = m_cause | r;
          if (r != 0) enter_hold();
          else if (edge_n >= deadline) begin
            if (RELEASE_GAP > 0) begin
              mode     = M_GAP;
              deadline = edge_n + int'(RELEASE_GAP);
            end else mode = M_IDLE;
          end
        end
        default: begin
          if (r != 0) begin
            m_cause = m_cause | r;
            enter_hold();
          end else if (edge_n >= deadline) mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic cycle(input logic [REQ_CNT-1:0] r, input logic b, input logic s);
    req = r; bus_cyc = b; rst = s;
    @(posedge clk);
    model(r, b, s);
    #1;
    chk("async_rst", 32'(async_rst), 32'(m_rst_now || prev_mode == M_HOLD));
    chk("sync_rst",  32'(sync_rst),  32'(m_rst_now || prev_mode == M_HOLD || prev_mode == M_GAP));
    chk("busy",      32'(busy),      32'(m_rst_now || prev_mode != M_IDLE));
    chk("cause",     32'(cause),     32'(m_cause));
    chk("forced",    32'(forced),    32'(m_forced));
  endtask

  int  na, ns, nd;
  bit  found;
  logic [REQ_CNT-1:0] rr;
  logic bb;

  initial begin
    req = '0; bus_cyc = 1'b0; rst = 1'b1;

    // Power-on reset: 5 cycles, then a 16-cycle async tail and 4 more of sync.
    repeat (5) cycle('0, 1'b0, 1'b1);
    na = 0; ns = 0;
    for (int i = 0; i < 30; i++) begin
      cycle('0, 1'b0, 1'b0);
      na += int'(async_rst); ns += int'(sync_rst);
    end
    chk("por_async_len", 32'(na), 32'(RST_CYCLES));
    chk("por_sync_len",  32'(ns), 32'(RST_CYCLES + RELEASE_GAP));
    chk("por_busy_end",  32'(busy), 32'(0));

    // Single request with an idle bus.
    cycle(4'b0010, 1'b0, 1'b0);
    na = 0; ns = 0;
    for (int i = 0; i < 30; i++) begin
      cycle('0, 1'b0, 1'b0);
      na += int'(async_rst); ns += int'(sync_rst);
    end
    chk("idle_req_async_len", 32'(na), 32'(RST_CYCLES));
    chk("idle_req_sync_len",  32'(ns), 32'(RST_CYCLES + RELEASE_GAP));
    chk("idle_req_cause",     32'(cause), 32'(4'b0010));
    chk("idle_req_forced",    32'(forced), 32'(0));

    // Drain that completes before the timeout.
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (10) cycle('0, 1'b1, 1'b0);
    repeat (30) cycle('0, 1'b0, 1'b0);
    chk("drain_cause",  32'(cause), 32'(4'b0100));
    chk("drain_forced", 32'(forced), 32'(0));

    // Drain timeout with the bus stuck busy.
    cycle(4'b1000, 1'b1, 1'b0);
    nd = 0;
    for (int i = 0; i < 120; i++) begin
      cycle('0, 1'b1, 1'b0);
      nd += int'(busy && !sync_rst);
    end
    chk("timeout_drain_len", 32'(nd), 32'(DRAIN_CYCLES));
    chk("timeout_forced",    32'(forced), 32'(1));
    chk("timeout_cause",     32'(cause), 32'(4'b1000));

    // Held request extends the pulse; a request during release re-enters.
    repeat (30) cycle(4'b0001, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle('0, 1'b0, 1'b0);
      if (sync_rst && !async_rst) found = 1'b1;
    end
    chk("reach_release", 32'(found), 32'(1));
    cycle(4'b0010, 1'b0, 1'b0);
    na = 0;
    for (int i = 0; i < 40; i++) begin
      cycle('0, 1'b0, 1'b0);
      na += int'(async_rst);
    end
    chk("reentry_async_len", 32'(na), 32'(RST_CYCLES));
    chk("reentry_cause",     32'(cause), 32'(4'b0011));

    // sync_rst_i in the middle of a drain.
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (5) cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b1);
    chk("midrst_cause",  32'(cause), 32'(0));
    chk("midrst_forced", 32'(forced), 32'(0));
    chk("midrst_async",  32'(async_rst), 32'(1));
    na = 0;
    for (int i = 0; i < 30; i++) begin
      cycle('0, 1'b1, 1'b0);
      na += int'(async_rst);
    end
    chk("midrst_async_len", 32'(na), 32'(RST_CYCLES));

    // Random traffic against the model.
    bb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) bb = ~bb;
      rr = ($urandom_range(0, 24) == 0) ? REQ_CNT'($urandom) : '0;
      cycle(rr, bb, ($urandom_range(0, 399) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
